// File: rtl/data_mem_mmio.sv
// Word-addressed data memory with a small MMIO register window: LED latch,
// free-running counter with compare/match interrupt, and synchronised switch inputs.
module data_mem_mmio #(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    localparam logic [9:0] OFF_LED    = 10'd0;
    localparam logic [9:0] OFF_CNT    = 10'd1;
    localparam logic [9:0] OFF_CMP    = 10'd2;
    localparam logic [9:0] OFF_CTRL   = 10'd3;
    localparam logic [9:0] OFF_STATUS = 10'd4;
    localparam logic [9:0] OFF_SW     = 10'd5;

    logic [31:0] mem [RAM_WORDS];

    logic [15:0] led_q,    led_d;
    logic [31:0] cnt_q,    cnt_d;
    logic [31:0] cmp_q,    cmp_d;
    logic        ctrl_q,   ctrl_d;
    logic        status_q, status_d;
    logic [15:0] sw_meta_q;
    logic [15:0] sw_sync_q;

    logic        ram_sel_s;
    logic        mmio_sel_s;
    logic [9:0]  off_s;
    logic [AW-1:0] widx_s;
    logic        ram_we_s;
    logic        reg_we_s;
    logic        unused_addr_s;

    // Byte lanes are not supported, so the low address bits carry no meaning.
    assign unused_addr_s = ^addr[1:0];

    assign ram_sel_s  = (addr[31:AW+2] == '0);
    assign mmio_sel_s = (addr[31:12] == MMIO_BASE[31:12]);
    assign off_s      = addr[11:2];
    assign widx_s     = addr[AW+1:2];
    assign ram_we_s   = MemWrite & ~reset & ram_sel_s;
    assign reg_we_s   = MemWrite & mmio_sel_s;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[widx_s] <= WD;
        end
    end

    // Register next-state: bus writes, counter increment, match set-over-clear.
    always_comb begin
        led_d    = led_q;
        cnt_d    = cnt_q + 32'd1;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        status_d = status_q;
        if (reg_we_s) begin
            case (off_s)
                OFF_LED:    led_d  = WD[15:0];
                OFF_CNT:    cnt_d  = WD;
                OFF_CMP:    cmp_d  = WD;
                OFF_CTRL:   ctrl_d = WD[0];
                OFF_STATUS: begin
                    if (WD[0]) begin
                        status_d = 1'b0;
                    end else begin
                        status_d = status_q;
                    end
                end
                default:    led_d  = led_q;
            endcase
        end else begin
            led_d = led_q;
        end
        // A compare hit in the same cycle as a clear must leave match set.
        if (cnt_q == cmp_q) begin
            status_d = 1'b1;
        end else begin
            status_d = status_d;
        end
    end

    // Register state and switch synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= 16'h0000;
            cnt_q     <= 32'h0000_0000;
            cmp_q     <= 32'h0000_0000;
            ctrl_q    <= 1'b0;
            status_q  <= 1'b0;
            sw_meta_q <= 16'h0000;
            sw_sync_q <= 16'h0000;
        end else begin
            led_q     <= led_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        RD = 32'h0000_0000;
        if (ram_sel_s) begin
            RD = mem[widx_s];
        end else if (mmio_sel_s) begin
            case (off_s)
                OFF_LED:    RD = {16'h0000, led_q};
                OFF_CNT:    RD = cnt_q;
                OFF_CMP:    RD = cmp_q;
                OFF_CTRL:   RD = {31'h0000_0000, ctrl_q};
                OFF_STATUS: RD = {31'h0000_0000, status_q};
                OFF_SW:     RD = {16'h0000, sw_sync_q};
                default:    RD = 32'h0000_0000;
            endcase
        end else begin
            RD = 32'h0000_0000;
        end
    end

    assign led       = led_q;
    assign timer_irq = status_q & ctrl_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed self-checking bench for data_mem_mmio: RAM, MMIO decode, counter,
// compare interrupt, switch synchroniser and reset behaviour.
module tb_data_mem_mmio;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] WD;
    logic [31:0] RD;
    logic [15:0] sw;
    logic [15:0] led;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    data_mem_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .WD        (WD),
        .RD        (RD),
        .sw        (sw),
        .led       (led),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus write completing at the next edge; returns 1 time unit after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr     = a;
        WD       = d;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, RD, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        MemWrite = 1'b0;
        addr     = 32'h0000_0000;
        WD       = 32'h0000_0000;
        sw       = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", {16'h0000, led}, 32'h0000_0000);
        check("rst_irq", {31'h0, timer_irq}, 32'h0000_0000);
        rd_chk("rst_cnt", 32'h0000_1004, 32'h0000_0000);
        reset = 1'b0;

        // RAM
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        wr(32'h0000_03FC, 32'h0000_1234);
        rd_chk("ram_3fc", 32'h0000_03FC, 32'h0000_1234);
        addr     = 32'h0000_0010;
        WD       = 32'h1111_2222;
        MemWrite = 1'b1;
        #1;
        check("ram_pre_edge", RD, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        check("ram_post_edge", RD, 32'h1111_2222);
        wr(32'h0000_0010, 32'hDEAD_BEEF);

        // MMIO decode
        wr(32'h0000_1000, 32'hFFFF_ABCD);
        check("led_port", {16'h0000, led}, 32'h0000_ABCD);
        rd_chk("led_rb", 32'h0000_1000, 32'h0000_ABCD);
        rd_chk("led_rb_unaligned", 32'h0000_1002, 32'h0000_ABCD);
        rd_chk("unmapped_2000", 32'h0000_2000, 32'h0000_0000);
        rd_chk("unmapped_1018", 32'h0000_1018, 32'h0000_0000);
        wr(32'h0000_1014, 32'h0000_FFFF);
        rd_chk("sw_ro", 32'h0000_1014, 32'h0000_0000);

        // Counter load and wrap
        wr(32'h0000_1004, 32'hFFFF_FFFE);
        rd_chk("cnt_fffe", 32'h0000_1004, 32'hFFFF_FFFE);
        tick();
        check("cnt_ffff", RD, 32'hFFFF_FFFF);
        tick();
        check("cnt_wrap", RD, 32'h0000_0000);

        // Compare and interrupt
        wr(32'h0000_1008, 32'd20);
        wr(32'h0000_100C, 32'h0000_0001);
        wr(32'h0000_1010, 32'h0000_0001);
        check("irq_cleared", {31'h0, timer_irq}, 32'h0000_0000);
        wr(32'h0000_1004, 32'd10);
        rd_chk("cnt_10", 32'h0000_1004, 32'd10);
        repeat (10) @(posedge clk);
        #1;
        check("cnt_20", RD, 32'd20);
        check("irq_not_yet", {31'h0, timer_irq}, 32'h0000_0000);
        tick();
        check("irq_rise", {31'h0, timer_irq}, 32'h0000_0001);
        rd_chk("status_set", 32'h0000_1010, 32'h0000_0001);
        wr(32'h0000_1010, 32'h0000_0000);
        check("irq_w0_keeps", {31'h0, timer_irq}, 32'h0000_0001);
        wr(32'h0000_1010, 32'h0000_0001);
        check("irq_w1c", {31'h0, timer_irq}, 32'h0000_0000);
        rd_chk("status_clr", 32'h0000_1010, 32'h0000_0000);

        // Set wins over same-cycle clear
        wr(32'h0000_1008, 32'd50);
        wr(32'h0000_1004, 32'd49);
        tick();
        rd_chk("cnt_50", 32'h0000_1004, 32'd50);
        wr(32'h0000_1010, 32'h0000_0001);
        rd_chk("set_wins", 32'h0000_1010, 32'h0000_0001);
        check("set_wins_irq", {31'h0, timer_irq}, 32'h0000_0001);

        // Switch synchroniser
        addr = 32'h0000_1014;
        sw   = 16'h00A5;
        #1;
        check("sw_c0", RD, 32'h0000_0000);
        tick();
        check("sw_c1", RD, 32'h0000_0000);
        tick();
        check("sw_c2", RD, 32'h0000_00A5);

        // One-cycle reset with a simultaneous LED write
        reset    = 1'b1;
        addr     = 32'h0000_1000;
        WD       = 32'h0000_5555;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        MemWrite = 1'b0;
        rd_chk("rst2_cnt", 32'h0000_1004, 32'h0000_0000);
        rd_chk("rst2_led", 32'h0000_1000, 32'h0000_0000);
        rd_chk("rst2_sw", 32'h0000_1014, 32'h0000_0000);
        rd_chk("rst2_status", 32'h0000_1010, 32'h0000_0000);
        rd_chk("rst2_ram", 32'h0000_0010, 32'hDEAD_BEEF);
        check("rst2_led_port", {16'h0000, led}, 32'h0000_0000);
        check("rst2_irq", {31'h0, timer_irq}, 32'h0000_0000);

        // RAM write ignored under reset
        tick();
        reset    = 1'b1;
        addr     = 32'h0000_0010;
        WD       = 32'h0000_0000;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        MemWrite = 1'b0;
        rd_chk("rst_ram_we_ignored", 32'h0000_0010, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameter RAM_WORDS, default 256, number of 32-bit RAM words; SHALL be a power of two, 16 to 1024.
REQ-002 Parameter MMIO_BASE, default 32'h0000_1000, base byte address of the register window; SHALL be 4 KB aligned.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port MemWrite  input  1  write strobe from the core, sampled at the rising edge.
REQ-006 Port addr  input  32  byte address from the core ALU result.
REQ-007 Port WD  input  32  write data from the core.
REQ-008 Port RD  output  32  read data to the core; combinational from addr within the same cycle.
REQ-009 Port sw  input  16  asynchronous switch inputs.
REQ-010 Port led  output  16  LED register value.
REQ-011 Port timer_irq  output  1  timer interrupt level.

Function
REQ-012 Accesses SHALL be word-only: addr[1:0] is ignored, there are no byte enables, and no misalignment fault is raised.
REQ-013 RAM region: addr < RAM_WORDS*4; word index is addr[log2(RAM_WORDS)+1:2]; writes complete at the clock edge, reads are combinational.
REQ-014 The MMIO map SHALL be, by offset from MMIO_BASE: 0x00 LED (RW, bits 15:0); 0x04 CNT (RW); 0x08 CMP (RW); 0x0C CTRL (RW, bit0 = irq_en); 0x10 STATUS (bit0 = match, write-1-to-clear); 0x14 SW (RO, bits 15:0).
REQ-015 Read-back SHALL zero-extend the unused upper bits of LED, CTRL, STATUS and SW.
REQ-016 Reads of any unmapped address SHALL return 32'h0; writes to any unmapped address or to SW SHALL be ignored.
REQ-017 CNT SHALL increment by 1 every cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-018 A CNT write SHALL load WD at the edge; on a simultaneous write and increment, the write wins, and the next cycle counts up from WD.
REQ-019 STATUS.match SHALL set at the edge following any cycle in which CNT == CMP, whether or not irq_en is set.
REQ-020 A STATUS write with WD[0]=1 SHALL clear match; WD[0]=0 has no effect.
REQ-021 If a STATUS clear and a new compare match occur in the same cycle, set SHALL win.
REQ-022 timer_irq SHALL equal STATUS.match AND CTRL.irq_en, combinationally.
REQ-023 sw SHALL pass through a two-flop synchronizer; SW read-back reflects a change at sw 2 edges later.
REQ-024 RD SHALL show pre-edge register or RAM contents; a write becomes visible to reads in the cycle after the edge.

Reset
REQ-025 While reset is high at an edge, LED, CNT, CMP, CTRL, STATUS and both synchronizer stages SHALL load 0; led=0 and timer_irq=0 from the next cycle.
REQ-026 RAM contents SHALL NOT be affected by reset, and MemWrite SHALL be ignored while reset is high.
REQ-027 Reset asserted mid-count SHALL give CNT=0 after the edge, with counting resuming on the first edge after reset deasserts.
REQ-028 Reset SHALL override any same-cycle register write.

Verification
REQ-029 RAM: write 32'hDEAD_BEEF to addr 0x10, then read 0x10 and 0x13 -> both return 32'hDEAD_BEEF; read 0x3FC before any write -> X is tolerated, but not after writing 0x1234 (then 0x1234).
REQ-030 MMIO decode: write 32'hFFFF_ABCD to LED -> led=16'hABCD and read-back 32'h0000_ABCD; read 0x2000 -> 0; write 0x1014 -> SW unchanged.
REQ-031 Counter: write CNT=32'hFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
REQ-032 Compare: CMP=20, CTRL=1, CNT=10 -> timer_irq rises in the cycle after CNT reads 20; write STATUS=1 -> irq drops the next cycle; write STATUS=0 instead -> irq stays high.
REQ-033 Set-wins: clear STATUS in the same cycle CNT==CMP -> match remains 1.
REQ-034 Synchronizer and reset: drive sw=16'h00A5 -> SW reads 0 for 2 cycles, then 0x00A5; assert reset for 1 cycle -> LED, CNT and SW read 0 and RAM word 0x10 still holds 32'hDEAD_BEEF.
